// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: FSM states, EStatus cause
// codes and the IRQ cause-code helper.
package exc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRaise   = 2'd1,
    StHandler = 2'd2,
    StReturn  = 2'd3
  } exc_state_e;

  localparam logic [3:0] ES_NONE     = 4'b0000;
  localparam logic [3:0] ES_INVOP    = 4'b0010;
  localparam logic [3:0] ES_MISAL    = 4'b0011;
  localparam logic [3:0] ES_IRQ_BASE = 4'b1000;

  // IRQ i reports as 1iii.
  function automatic logic [3:0] irq_code(input logic [2:0] idx);
    return ES_IRQ_BASE | {1'b0, idx};
  endfunction

endpackage

// File: rtl/irq_pending.sv
// Edge detection and pending latch for the external interrupt lines, plus a
// lowest-index-first priority encoder over the enabled pending set.
//   clk_i, rst_ni  : clock, async active-low reset
//   irq_req_i      : raw interrupt lines (rising edge sets pending)
//   en_i           : global enable applied to selection only
//   clr_mask_i     : bits to clear (IRQ taken this cycle)
//   sel_idx_o      : index of highest-priority enabled pending IRQ
//   sel_valid_o    : sel_idx_o is meaningful
//   pending_o      : pending register
module irq_pending #(
  parameter int unsigned NIRQ = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NIRQ-1:0] irq_req_i,
  input  logic            en_i,
  input  logic [NIRQ-1:0] clr_mask_i,
  output logic [2:0]      sel_idx_o,
  output logic            sel_valid_o,
  output logic [NIRQ-1:0] pending_o
);

  logic [NIRQ-1:0] irq_prev_q;
  logic [NIRQ-1:0] pending_q, pending_d;

  // A fresh edge on a line being cleared wins, so it stays pending.
  assign pending_d = (pending_q & ~clr_mask_i) | (irq_req_i & ~irq_prev_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_req_i;
      pending_q  <= pending_d;
    end
  end

  // Scan high to low so the lowest index overrides.
  always_comb begin
    sel_idx_o   = 3'd0;
    sel_valid_o = 1'b0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (en_i && pending_q[i]) begin
        sel_idx_o   = 3'(i);
        sel_valid_o = 1'b1;
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/exception_controller.sv
// Exception/return sequencer for the single-cycle datapath. Prioritises
// synchronous faults over external IRQs, raises exc_o with a cause code,
// waits for exc_ack_i (with timeout), masks new exceptions while in the
// handler and pulses eret_o on ERET.
//   clk_i, rst_ni    : clock, async active-low reset
//   irq_req_i        : external interrupt lines (edge-triggered)
//   irq_en_i         : global IRQ enable (faults are never masked)
//   invalid_op_i     : undefined opcode in current instruction
//   misaligned_i     : misaligned load/store address
//   eret_op_i        : current instruction is ERET
//   exc_ack_i        : datapath has vectored to the handler
//   exc_o            : exception request
//   eret_o           : one-cycle return pulse
//   estatus_o        : cause code
//   irq_ack_o        : one-hot pulse for the IRQ taken
//   in_handler_o     : high while in the handler
//   ack_err_o        : sticky ack-timeout flag
//   dbl_fault_o      : sticky fault-inside-handler flag
module exception_controller
  import exc_pkg::*;
#(
  parameter int unsigned NIRQ        = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NIRQ-1:0] irq_req_i,
  input  logic            irq_en_i,
  input  logic            invalid_op_i,
  input  logic            misaligned_i,
  input  logic            eret_op_i,
  input  logic            exc_ack_i,
  output logic            exc_o,
  output logic            eret_o,
  output logic [3:0]      estatus_o,
  output logic [NIRQ-1:0] irq_ack_o,
  output logic            in_handler_o,
  output logic            ack_err_o,
  output logic            dbl_fault_o
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT);

  exc_state_e      state_q;
  logic            exc_q, eret_q, in_handler_q, ack_err_q, dbl_fault_q;
  logic [3:0]      estatus_q;
  logic [NIRQ-1:0] irq_ack_q;
  logic [TW-1:0]   timer_q;

  logic [2:0]      sel_idx;
  logic            sel_valid;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] sel_onehot;
  logic [NIRQ-1:0] clr_mask;
  logic            take_irq;

  irq_pending #(
    .NIRQ(NIRQ)
  ) u_irq_pending (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .irq_req_i  (irq_req_i),
    .en_i       (irq_en_i),
    .clr_mask_i (clr_mask),
    .sel_idx_o  (sel_idx),
    .sel_valid_o(sel_valid),
    .pending_o  (pending)
  );

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < int'(NIRQ); i++) begin
      sel_onehot[i] = (sel_idx == 3'(i));
    end
  end

  // An IRQ is only taken from idle when no synchronous fault outranks it.
  assign take_irq = (state_q == StIdle) && !invalid_op_i && !misaligned_i && sel_valid;
  assign clr_mask = take_irq ? (sel_onehot & pending) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      exc_q        <= 1'b0;
      eret_q       <= 1'b0;
      estatus_q    <= ES_NONE;
      irq_ack_q    <= '0;
      in_handler_q <= 1'b0;
      ack_err_q    <= 1'b0;
      dbl_fault_q  <= 1'b0;
      timer_q      <= '0;
    end else begin
      irq_ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (invalid_op_i) begin
            state_q   <= StRaise;
            exc_q     <= 1'b1;
            estatus_q <= ES_INVOP;
            timer_q   <= '0;
          end else if (misaligned_i) begin
            state_q   <= StRaise;
            exc_q     <= 1'b1;
            estatus_q <= ES_MISAL;
            timer_q   <= '0;
          end else if (take_irq) begin
            state_q   <= StRaise;
            exc_q     <= 1'b1;
            estatus_q <= irq_code(sel_idx);
            timer_q   <= '0;
            irq_ack_q <= sel_onehot;
          end
        end
        StRaise: begin
          if (exc_ack_i) begin
            exc_q        <= 1'b0;
            in_handler_q <= 1'b1;
            state_q      <= StHandler;
          end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
            // Abandon the request; a taken IRQ is dropped, not re-pended.
            exc_q     <= 1'b0;
            ack_err_q <= 1'b1;
            estatus_q <= ES_NONE;
            state_q   <= StIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StHandler: begin
          if (invalid_op_i || misaligned_i) begin
            dbl_fault_q <= 1'b1;
          end
          if (eret_op_i) begin
            eret_q  <= 1'b1;
            state_q <= StReturn;
          end
        end
        StReturn: begin
          eret_q       <= 1'b0;
          estatus_q    <= ES_NONE;
          in_handler_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign exc_o        = exc_q;
  assign eret_o       = eret_q;
  assign estatus_o    = estatus_q;
  assign irq_ack_o    = irq_ack_q;
  assign in_handler_o = in_handler_q;
  assign ack_err_o    = ack_err_q;
  assign dbl_fault_o  = dbl_fault_q;

endmodule
